// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_e : FSM states used by the serial datapaths (2-bit encoding)
//   ARITH_W : default operand width for the arithmetic set
package serial_arith_pkg;

  localparam int ARITH_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// 1-bit full adder cell, purely combinational.
// Ports:
//   a_i, b_i  : operand bits
//   cin_i     : carry in
//   s_o       : sum bit
//   cout_o    : carry out (majority of the three inputs)
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: adds two WIDTH-bit operands LSB-first, one bit
// per clock, through a single full-adder cell and a registered carry. The
// last result is held on sum/cout until the next addition completes.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   start : request an addition (accepted only in IDLE)
//   a, b  : operands, captured on the accepting edge
//   sum   : registered (a+b) mod 2^WIDTH
//   cout  : registered carry-out
//   busy  : high while the addition is in progress
//   done  : one-cycle pulse when sum/cout are updated
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q, acc_q;
  logic [WIDTH-1:0]   sum_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q, cout_q, busy_q, done_q;

  logic               s_bit, c_bit;
  logic [WIDTH-1:0]   acc_d;

  full_adder u_fa (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .cin_i  (carry_q),
    .s_o    (s_bit),
    .cout_o (c_bit)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts the LSB-first
  // stream lands in its natural bit order.
  generate
    if (WIDTH > 1) begin : g_acc_wide
      assign acc_d = {s_bit, acc_q[WIDTH-1:1]};
    end else begin : g_acc_one
      assign acc_d = s_bit;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc_q   <= acc_d;
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= c_bit;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            sum_q   <= acc_d;
            cout_q  <= c_bit;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // Start requests are ignored here; the next one is taken in IDLE.
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
